player_link_scheduler: RTL and testbench

- Sequences player events onto the single UART transmit channel. The player controller produces lane state plus fire and projectile-switch events; this block turns them into one-byte packets.
- The block arbitrates between four packet sources (fire, switch, lane change, heartbeat) and drives the UART TX byte interface with a valid/ready handshake.
- It sits between player_controller and the UART transmitter.

---
 rtl/player_link_scheduler_pkg.sv | 36 +++
 rtl/player_link_scheduler_if.sv | 9 +
 rtl/player_link_scheduler_arbiter.sv | 19 +
 rtl/player_link_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_player_link_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_link_scheduler_pkg.sv
// Shared definitions for the player link scheduler: packet types, FSM states,
// lane bounds and the packet-byte builder.
package player_link_pkg;

    typedef enum logic [1:0] {
        TYPE_LANE   = 2'b00,
        TYPE_FIRE   = 2'b01,
        TYPE_SWITCH = 2'b10,
        TYPE_HB     = 2'b11
    } pkt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } link_state_t;

    localparam logic [3:0] LANE_MIN = 4'd1;
    localparam logic [3:0] LANE_MAX = 4'd9;

    // Request slots as seen by the arbiter; lower index wins.
    localparam logic [1:0] PRI_FIRE   = 2'd0;
    localparam logic [1:0] PRI_SWITCH = 2'd1;
    localparam logic [1:0] PRI_LANE   = 2'd2;
    localparam logic [1:0] PRI_HB     = 2'd3;

    function automatic logic [7:0] make_packet(input pkt_type_t t, input logic ptype,
                                               input logic [3:0] lane);
        return {t, ptype, 1'b0, lane};
    endfunction

    function automatic logic lane_is_legal(input logic [3:0] lane);
        return (lane >= LANE_MIN) && (lane <= LANE_MAX);
    endfunction

endpackage

// File: rtl/player_link_scheduler_if.sv
// Byte stream towards the UART transmitter: valid/ready handshake plus data.
interface player_link_scheduler_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/player_link_scheduler_arbiter.sv
// Combinational 4-way fixed-priority arbiter; request 0 has the highest priority.
module link_priority_arbiter (
    input  logic [3:0] i_req,
    output logic       o_any,
    output logic [3:0] o_grant,
    output logic [1:0] o_idx
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pri
            // A request wins only if nothing of higher priority is asking.
            localparam logic [3:0] HIGHER_MASK = 4'((1 << gi) - 1);
            assign o_grant[gi] = i_req[gi] & ~(|(i_req & HIGHER_MASK));
        end
    endgenerate

    assign o_any = |i_req;
    assign o_idx = {o_grant[2] | o_grant[3], o_grant[1] | o_grant[3]};
endmodule

// File: rtl/player_link_scheduler.sv
// Turns player fire/switch/lane events and a liveness heartbeat into one-byte
// packets on the UART TX handshake, one packet at a time with a trailing gap.
module player_link_scheduler
    import player_link_pkg::*;
#(
    parameter int HEARTBEAT_CYCLES = 1000000,
    parameter int GAP_CYCLES       = 4,
    parameter int DROP_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            lane,
    input  logic                  proj_type,
    input  logic                  fire_pulse,
    input  logic                  switch_pulse,
    player_link_scheduler_if.master tx,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_count
);
    localparam int HB_W  = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    link_state_t       r_state;
    logic              r_valid;
    logic [7:0]        r_data;
    logic              r_busy;
    logic [3:0]        r_last_lane;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [HB_W-1:0]   r_hb_cnt;
    logic [DROP_W-1:0] r_drop;
    logic              r_pend_fire;
    logic              r_fire_ptype;
    logic              r_pend_switch;
    logic              r_pend_lane;
    logic              r_pend_hb;

    logic              w_any;
    logic [3:0]        w_grant_raw;
    logic [3:0]        w_grant;
    logic [1:0]        w_idx;
    logic              w_handshake;
    logic              w_lane_new;
    pkt_type_t         w_type;
    logic              w_ptype;
    logic [7:0]        w_packet;

    link_priority_arbiter u_arb (
        .i_req   ({r_pend_hb, r_pend_lane, r_pend_switch, r_pend_fire}),
        .o_any   (w_any),
        .o_grant (w_grant_raw),
        .o_idx   (w_idx)
    );

    assign w_grant     = (r_state == ST_IDLE) ? w_grant_raw : 4'b0000;
    assign w_handshake = r_valid & tx.tx_ready;
    assign w_lane_new  = lane_is_legal(lane) && (lane != r_last_lane);

    // FIRE carries the type latched with its pulse; the others take it at grant.
    always_comb begin
        w_type  = TYPE_HB;
        w_ptype = proj_type;
        case (w_idx)
            PRI_FIRE: begin
                w_type  = TYPE_FIRE;
                w_ptype = r_fire_ptype;
            end
            PRI_SWITCH: w_type = TYPE_SWITCH;
            PRI_LANE:   w_type = TYPE_LANE;
            default:    w_type = TYPE_HB;
        endcase
    end

    assign w_packet = make_packet(w_type, w_ptype, lane);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_data      <= 8'h00;
            r_busy      <= 1'b0;
            r_last_lane <= 4'd0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_valid <= 1'b1;
                        r_data  <= w_packet;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        r_valid     <= 1'b0;
                        r_last_lane <= r_data[3:0];
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A fire arriving while an older fire still waits is counted as lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_fire   <= 1'b0;
            r_fire_ptype  <= 1'b0;
            r_pend_switch <= 1'b0;
            r_drop        <= '0;
        end else begin
            if (fire_pulse) begin
                r_pend_fire <= 1'b1;
                if (r_pend_fire && !w_grant[PRI_FIRE]) begin
                    if (!(&r_drop))
                        r_drop <= r_drop + 1'b1;
                end else begin
                    r_fire_ptype <= proj_type;
                end
            end else if (w_grant[PRI_FIRE]) begin
                r_pend_fire <= 1'b0;
            end

            if (switch_pulse)
                r_pend_switch <= 1'b1;
            else if (w_grant[PRI_SWITCH])
                r_pend_switch <= 1'b0;
        end
    end

    // Any handshake refreshes both lane and liveness state; the lane flag is
    // re-evaluated next cycle against the lane that just went out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_lane <= 1'b0;
            r_pend_hb   <= 1'b0;
            r_hb_cnt    <= '0;
        end else begin
            if (w_handshake)
                r_pend_lane <= 1'b0;
            else if (w_lane_new)
                r_pend_lane <= 1'b1;
            else if (w_grant[PRI_LANE])
                r_pend_lane <= 1'b0;

            if (w_handshake) begin
                r_pend_hb <= 1'b0;
                r_hb_cnt  <= '0;
            end else begin
                if (r_hb_cnt == HB_LAST)
                    r_pend_hb <= 1'b1;
                else if (w_grant[PRI_HB])
                    r_pend_hb <= 1'b0;
                if (r_hb_cnt != HB_LAST)
                    r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign tx.tx_valid = r_valid;
    assign tx.tx_data  = r_data;
    assign busy        = r_busy;
    assign drop_count  = r_drop;

endmodule

// File: tb/tb_player_link_scheduler.sv
// Directed bench for player_link_scheduler: a behavioural link model is compared
// against the DUT every cycle, plus hand-computed byte sequences and timings.
module tb_player_link_scheduler;
    localparam int HBC  = 16;
    localparam int GAPC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] lane = 4'd5;
    logic       proj_type = 1'b0;
    logic       fire_pulse = 1'b0;
    logic       switch_pulse = 1'b0;
    logic       busy;
    logic [7:0] drop_count;

    player_link_scheduler_if u_if ();

    player_link_scheduler #(
        .HEARTBEAT_CYCLES (HBC),
        .GAP_CYCLES       (GAPC),
        .DROP_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lane         (lane),
        .proj_type    (proj_type),
        .fire_pulse   (fire_pulse),
        .switch_pulse (switch_pulse),
        .tx           (u_if),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    int hs_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int got_at(input int i);
        if (i < got_q.size()) return int'(got_q[i]);
        return -1;
    endfunction

    function automatic logic [7:0] pkt(input logic [1:0] t, input logic p, input logic [3:0] l);
        return {t, p, 1'b0, l};
    endfunction

    // Behavioural model: link either sending, resting for GAPC cycles, or free.
    bit         m_valid;
    bit         m_busy;
    logic [7:0] m_data;
    int         m_drop;
    bit         pend[4];      // 0 fire, 1 switch, 2 lane, 3 heartbeat
    bit         m_fpt;
    int         m_last;
    int         m_hb;
    int         m_gap;

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_data = 8'h00; m_drop = 0; m_fpt = 0;
        m_last = 0; m_hb = 0; m_gap = 0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
    endtask

    task automatic model_step();
        bit hs;
        bit free_link;
        int g;
        logic [1:0] t;
        logic [7:0] nd;
        hs = m_valid && (u_if.tx_ready === 1'b1);
        free_link = !m_valid && (m_gap == 0);
        g = -1;
        if (free_link)
            for (int i = 0; i < 4; i++)
                if (pend[i] && g < 0) g = i;
        case (g)
            0: t = 2'b01;
            1: t = 2'b10;
            2: t = 2'b00;
            default: t = 2'b11;
        endcase
        nd = pkt(t, (g == 0) ? m_fpt : proj_type, lane);

        if (fire_pulse) begin
            if (pend[0] && g != 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_fpt = proj_type;
            end
            pend[0] = 1;
        end else if (g == 0) pend[0] = 0;

        if (switch_pulse) pend[1] = 1;
        else if (g == 1) pend[1] = 0;

        if (hs) pend[2] = 0;
        else if (lane >= 4'd1 && lane <= 4'd9 && int'(lane) != m_last) pend[2] = 1;
        else if (g == 2) pend[2] = 0;

        if (hs) begin
            pend[3] = 0;
            m_hb = 0;
        end else begin
            if (m_hb == HBC - 1) pend[3] = 1;
            else if (g == 3) pend[3] = 0;
            if (m_hb < HBC - 1) m_hb++;
        end

        if (hs) begin
            m_valid = 0;
            m_last = int'(m_data[3:0]);
            m_gap = GAPC;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data = nd;
        end
        m_busy = m_valid || (m_gap > 0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("tx_valid", 32'(u_if.tx_valid), 32'(m_valid));
        if (m_valid) chk("tx_data", 32'(u_if.tx_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        if (rst && u_if.tx_valid && u_if.tx_ready) begin
            $display("tx  cycle=%0d byte=0x%02h drop=%0d", cyc, u_if.tx_data, drop_count);
            got_q.push_back(u_if.tx_data);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int limit);
        int k;
        k = 0;
        while (u_if.tx_valid !== 1'b1 && k < limit) begin
            tick(1);
            k++;
        end
        chk("wait_valid_timeout", 32'(u_if.tx_valid), 1);
    endtask

    // Reset, release, and confirm the first byte is the LANE packet one cycle
    // after its flag is set.
    task automatic do_reset(input logic [3:0] l, input logic p, input logic [7:0] first_byte);
        rst = 1'b0;
        fire_pulse = 1'b0;
        switch_pulse = 1'b0;
        lane = l;
        proj_type = p;
        u_if.tx_ready = 1'b1;
        tick(2);
        chk("rst_valid", 32'(u_if.tx_valid), 0);
        chk("rst_data", 32'(u_if.tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_count), 0);
        got_q.delete();
        rst = 1'b1;
        tick(1);
        chk("first_lat_e0", 32'(u_if.tx_valid), 0);
        tick(1);
        chk("first_lat_e1", 32'(u_if.tx_valid), 1);
        chk("first_byte", 32'(u_if.tx_data), 32'(first_byte));
        tick(1);
        chk("first_done", 32'(u_if.tx_valid), 0);
        chk("first_gap_busy", 32'(busy), 1);
        chk("first_count", got_q.size(), 1);
        got_q.delete();
    endtask

    initial begin
        u_if.tx_ready = 1'b1;

        // Reset release: one LANE byte 0x05, then the link falls quiet.
        do_reset(4'd5, 1'b0, 8'h05);
        tick(10);
        chk("t1_quiet_bytes", got_q.size(), 0);
        chk("t1_quiet_busy", 32'(busy), 0);

        // FIRE at lane 5 with ptype 1 held 10 cycles under back-pressure.
        do_reset(4'd5, 1'b0, 8'h05);
        proj_type = 1'b1;
        u_if.tx_ready = 1'b0;
        fire_pulse = 1'b1;
        tick(1);
        fire_pulse = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", 32'(u_if.tx_valid), 1);
            chk("t2_hold_data", 32'(u_if.tx_data), 32'h65);
            tick(1);
        end
        chk("t2_11th_valid", 32'(u_if.tx_valid), 1);
        u_if.tx_ready = 1'b1;
        tick(1);
        chk("t2_after_hs", 32'(u_if.tx_valid), 0);
        tick(2);
        chk("t2_count", got_q.size(), 1);
        chk("t2_byte", got_at(0), 32'h65);

        // Fire, switch and lane 6 together: FIRE then SWITCH, lane already covered.
        do_reset(4'd5, 1'b0, 8'h05);
        fire_pulse = 1'b1;
        switch_pulse = 1'b1;
        lane = 4'd6;
        tick(1);
        fire_pulse = 1'b0;
        switch_pulse = 1'b0;
        tick(20);
        chk("t3_count", got_q.size(), 2);
        chk("t3_byte0", got_at(0), 32'h46);
        chk("t3_byte1", got_at(1), 32'h86);

        // Three back-to-back fires while the first is still pending: two drops.
        do_reset(4'd5, 1'b0, 8'h05);
        u_if.tx_ready = 1'b0;
        fire_pulse = 1'b1;
        tick(3);
        fire_pulse = 1'b0;
        chk("t4_drop", 32'(drop_count), 2);
        wait_valid(20);
        chk("t4_data", 32'(u_if.tx_data), 32'h45);
        tick(2);
        u_if.tx_ready = 1'b1;
        tick(9);
        chk("t4_count", got_q.size(), 1);
        chk("t4_byte", got_at(0), 32'h45);
        chk("t4_drop_kept", 32'(drop_count), 2);

        // Fire landing on the cycle its flag is granted re-arms without a drop.
        do_reset(4'd5, 1'b0, 8'h05);
        proj_type = 1'b1;
        fire_pulse = 1'b1;
        tick(1);
        fire_pulse = 1'b0;
        tick(3);
        fire_pulse = 1'b1;
        proj_type = 1'b0;
        tick(1);
        fire_pulse = 1'b0;
        tick(12);
        chk("t5_count", got_q.size(), 2);
        chk("t5_byte0", got_at(0), 32'h65);
        chk("t5_byte1", got_at(1), 32'h45);
        chk("t5_drop", 32'(drop_count), 0);

        // Illegal lanes 12 and 0 are ignored; lane 9 is sent.
        do_reset(4'd5, 1'b0, 8'h05);
        lane = 4'd12;
        tick(5);
        lane = 4'd0;
        tick(4);
        chk("t6_illegal_quiet", got_q.size(), 0);
        lane = 4'd9;
        tick(4);
        chk("t6_count", got_q.size(), 1);
        chk("t6_byte", got_at(0), 32'h09);

        // Drop counter saturates at all-ones under a long stall.
        do_reset(4'd5, 1'b0, 8'h05);
        u_if.tx_ready = 1'b0;
        fire_pulse = 1'b1;
        tick(262);
        fire_pulse = 1'b0;
        chk("t7_drop_sat", 32'(drop_count), 32'hFF);
        u_if.tx_ready = 1'b1;
        tick(12);
        chk("t7_count", got_q.size(), 2);
        chk("t7_byte0", got_at(0), 32'h45);
        chk("t7_byte1", got_at(1), 32'h45);

        // Heartbeats at lane 3, ptype 1. The counter runs through SEND and GAP
        // too, so handshakes are HBC+2 cycles apart.
        hs_cyc.delete();
        do_reset(4'd3, 1'b1, 8'h23);
        tick(60);
        chk("t8_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("t8_hb_byte", got_at(i), 32'hE3);
        chk("t8_hs_count", hs_cyc.size(), 4);
        for (int i = 1; i < 4 && i < hs_cyc.size(); i++)
            chk("t8_hb_period", hs_cyc[i] - hs_cyc[i-1], 18);

        // Reset in the middle of SEND abandons the byte at once.
        do_reset(4'd5, 1'b0, 8'h05);
        u_if.tx_ready = 1'b0;
        fire_pulse = 1'b1;
        tick(1);
        fire_pulse = 1'b0;
        wait_valid(20);
        chk("t9_send_data", 32'(u_if.tx_data), 32'h45);
        rst = 1'b0;
        #1;
        chk("t9_async_valid", 32'(u_if.tx_valid), 0);
        chk("t9_async_busy", 32'(busy), 0);
        do_reset(4'd5, 1'b0, 8'h05);
        chk("t9_drop", 32'(drop_count), 0);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
